message_dispatcher: RTL and testbench

MESSAGE_DISPATCHER -- requirements
Module: message_dispatcher

---
 rtl/message_dispatcher.sv | 127 ++++++++++++
 tb/tb_message_dispatcher.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/message_dispatcher.sv
// -----------------------------------------------------------------------------
// message_dispatcher
//
// Routes requests from the issue stage into one of two independent queues.
// One queue feeds the post office and the other feeds the mailbox. Each queue
// is a DEPTH-entry FIFO with ready/valid handshakes on both of its sides.
//
// Ports
//   clk                          : single clock; all state changes on its rising edge
//   rst_n                        : asynchronous active-low reset
//   flush                        : synchronous flush; blocks every handshake and
//                                  empties both queues at the next edge
//   issue_dispatcher_valid       : issue stage presents a request
//   dispatcher_issue_ready       : request is accepted this cycle
//   issue_dispatcher_target      : destination select (0 = post office, 1 = mailbox)
//   issue_dispatcher_data        : request payload
//   dispatcher_postoffice_valid  : post-office queue head is valid
//   postoffice_dispatcher_ready  : post office consumes the head
//   dispatcher_postoffice_data   : post-office queue head payload
//   dispatcher_mailbox_valid     : mailbox queue head is valid
//   mailbox_dispatcher_ready     : mailbox consumes the head
//   dispatcher_mailbox_data      : mailbox queue head payload
//   dispatcher_idle              : both queues are empty
// -----------------------------------------------------------------------------
module message_dispatcher #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              issue_dispatcher_valid,
  output logic              dispatcher_issue_ready,
  input  logic              issue_dispatcher_target,
  input  logic [DATA_W-1:0] issue_dispatcher_data,
  output logic              dispatcher_postoffice_valid,
  input  logic              postoffice_dispatcher_ready,
  output logic [DATA_W-1:0] dispatcher_postoffice_data,
  output logic              dispatcher_mailbox_valid,
  input  logic              mailbox_dispatcher_ready,
  output logic [DATA_W-1:0] dispatcher_mailbox_data,
  output logic              dispatcher_idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_po [DEPTH];
  logic [DATA_W-1:0] mem_mb [DEPTH];

  logic [PTR_W-1:0] rd_ptr_po, wr_ptr_po;
  logic [PTR_W-1:0] rd_ptr_mb, wr_ptr_mb;
  logic [CNT_W-1:0] count_po, count_mb;

  logic full_po, full_mb;
  logic push_po, push_mb;
  logic pop_po, pop_mb;

  assign full_po = (count_po == FULL_COUNT);
  assign full_mb = (count_mb == FULL_COUNT);

  // Ready depends only on the selected queue. A stalled destination therefore
  // never blocks the other one. A full queue stays not-ready even if it pops
  // in the same cycle, which keeps ready off the consumer-ready path.
  assign dispatcher_issue_ready = !flush &&
                                  !(issue_dispatcher_target ? full_mb : full_po);

  assign push_po = issue_dispatcher_valid && dispatcher_issue_ready && !issue_dispatcher_target;
  assign push_mb = issue_dispatcher_valid && dispatcher_issue_ready &&  issue_dispatcher_target;

  assign dispatcher_postoffice_valid = !flush && (count_po != '0);
  assign dispatcher_mailbox_valid    = !flush && (count_mb != '0);
  assign dispatcher_postoffice_data  = mem_po[rd_ptr_po];
  assign dispatcher_mailbox_data     = mem_mb[rd_ptr_mb];

  // Each valid already includes !flush, so a flush cycle can never pop.
  assign pop_po = dispatcher_postoffice_valid && postoffice_dispatcher_ready;
  assign pop_mb = dispatcher_mailbox_valid    && mailbox_dispatcher_ready;

  assign dispatcher_idle = (count_po == '0) && (count_mb == '0);

  // Payload storage has no reset. Only the pointers and counts decide which
  // entries are valid, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push_po) mem_po[wr_ptr_po] <= issue_dispatcher_data;
    if (push_mb) mem_mb[wr_ptr_mb] <= issue_dispatcher_data;
  end

  // Post-office queue bookkeeping. DEPTH is a power of two, so the pointers
  // wrap naturally at their bit width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_po <= '0;
      wr_ptr_po <= '0;
      count_po  <= '0;
    end else if (flush) begin
      rd_ptr_po <= '0;
      wr_ptr_po <= '0;
      count_po  <= '0;
    end else begin
      if (push_po) wr_ptr_po <= wr_ptr_po + 1'b1;
      if (pop_po)  rd_ptr_po <= rd_ptr_po + 1'b1;
      if (push_po && !pop_po)      count_po <= count_po + 1'b1;
      else if (pop_po && !push_po) count_po <= count_po - 1'b1;
    end
  end

  // Mailbox queue bookkeeping. This mirrors the post-office queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_mb <= '0;
      wr_ptr_mb <= '0;
      count_mb  <= '0;
    end else if (flush) begin
      rd_ptr_mb <= '0;
      wr_ptr_mb <= '0;
      count_mb  <= '0;
    end else begin
      if (push_mb) wr_ptr_mb <= wr_ptr_mb + 1'b1;
      if (pop_mb)  rd_ptr_mb <= rd_ptr_mb + 1'b1;
      if (push_mb && !pop_mb)      count_mb <= count_mb + 1'b1;
      else if (pop_mb && !push_mb) count_mb <= count_mb - 1'b1;
    end
  end

endmodule

// File: tb/tb_message_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_message_dispatcher
//
// Directed, self-checking bench for message_dispatcher with DATA_W=64 and
// DEPTH=2. Inputs change 1 time unit after the rising edge. Outputs are
// sampled 1 time unit after that, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_message_dispatcher;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        issue_dispatcher_valid;
  logic        dispatcher_issue_ready;
  logic        issue_dispatcher_target;
  logic [63:0] issue_dispatcher_data;
  logic        dispatcher_postoffice_valid;
  logic        postoffice_dispatcher_ready;
  logic [63:0] dispatcher_postoffice_data;
  logic        dispatcher_mailbox_valid;
  logic        mailbox_dispatcher_ready;
  logic [63:0] dispatcher_mailbox_data;
  logic        dispatcher_idle;

  int testsRun;
  int testsFailed;

  message_dispatcher #(.DATA_W(64), .DEPTH(2)) dut (
    .clk                         (clk),
    .rst_n                       (rst_n),
    .flush                       (flush),
    .issue_dispatcher_valid      (issue_dispatcher_valid),
    .dispatcher_issue_ready      (dispatcher_issue_ready),
    .issue_dispatcher_target     (issue_dispatcher_target),
    .issue_dispatcher_data       (issue_dispatcher_data),
    .dispatcher_postoffice_valid (dispatcher_postoffice_valid),
    .postoffice_dispatcher_ready (postoffice_dispatcher_ready),
    .dispatcher_postoffice_data  (dispatcher_postoffice_data),
    .dispatcher_mailbox_valid    (dispatcher_mailbox_valid),
    .mailbox_dispatcher_ready    (mailbox_dispatcher_ready),
    .dispatcher_mailbox_data     (dispatcher_mailbox_data),
    .dispatcher_idle             (dispatcher_idle)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive every input, then let the combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic t, input logic [63:0] d,
                               input logic po_rdy, input logic mb_rdy,
                               input logic fl);
    issue_dispatcher_valid      = v;
    issue_dispatcher_target     = t;
    issue_dispatcher_data       = d;
    postoffice_dispatcher_ready = po_rdy;
    mailbox_dispatcher_ready    = mb_rdy;
    flush                       = fl;
    #1;
  endtask

  // Advance to 1 unit past the next rising edge.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_po_valid", 64'(dispatcher_postoffice_valid), 64'd0);
    checkOutput("reset_mb_valid", 64'(dispatcher_mailbox_valid), 64'd0);
    checkOutput("reset_idle", 64'(dispatcher_idle), 64'd1);
    checkOutput("reset_ready", 64'(dispatcher_issue_ready), 64'd1);
    rst_n = 1'b1;
    stepClock();

    // Single request to the post office with one cycle of latency
    applyStimulus(1'b1, 1'b0, 64'h1234, 1'b1, 1'b0, 1'b0);
    checkOutput("single_ready", 64'(dispatcher_issue_ready), 64'd1);
    checkOutput("single_idle_before", 64'(dispatcher_idle), 64'd1);
    checkOutput("single_no_bypass", 64'(dispatcher_postoffice_valid), 64'd0);
    stepClock();
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("single_po_valid", 64'(dispatcher_postoffice_valid), 64'd1);
    checkOutput("single_po_data", dispatcher_postoffice_data, 64'h1234);
    checkOutput("single_idle_busy", 64'(dispatcher_idle), 64'd0);
    stepClock();
    checkOutput("single_po_drained", 64'(dispatcher_postoffice_valid), 64'd0);
    checkOutput("single_idle_after", 64'(dispatcher_idle), 64'd1);

    // Fill the mailbox and apply backpressure
    applyStimulus(1'b1, 1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    checkOutput("fill_ready_a", 64'(dispatcher_issue_ready), 64'd1);
    stepClock();
    applyStimulus(1'b1, 1'b1, 64'hB, 1'b0, 1'b0, 1'b0);
    checkOutput("fill_ready_b", 64'(dispatcher_issue_ready), 64'd1);
    checkOutput("fill_mb_head_a", dispatcher_mailbox_data, 64'hA);
    stepClock();
    applyStimulus(1'b1, 1'b1, 64'hC, 1'b0, 1'b0, 1'b0);
    checkOutput("fill_ready_c_full", 64'(dispatcher_issue_ready), 64'd0);
    stepClock();
    applyStimulus(1'b1, 1'b1, 64'hC, 1'b0, 1'b1, 1'b0);
    checkOutput("fill_full_pop_no_pass", 64'(dispatcher_issue_ready), 64'd0);
    checkOutput("fill_mb_out_a", dispatcher_mailbox_data, 64'hA);
    checkOutput("fill_mb_valid_a", 64'(dispatcher_mailbox_valid), 64'd1);
    stepClock();
    checkOutput("fill_ready_c_room", 64'(dispatcher_issue_ready), 64'd1);
    checkOutput("fill_mb_out_b", dispatcher_mailbox_data, 64'hB);
    stepClock();
    applyStimulus(1'b0, 1'b1, 64'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("fill_mb_out_c", dispatcher_mailbox_data, 64'hC);
    checkOutput("fill_mb_valid_c", 64'(dispatcher_mailbox_valid), 64'd1);
    stepClock();
    checkOutput("fill_mb_empty", 64'(dispatcher_mailbox_valid), 64'd0);
    checkOutput("fill_idle", 64'(dispatcher_idle), 64'd1);

    // A stalled mailbox must not block post-office traffic
    applyStimulus(1'b1, 1'b1, 64'h1, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 1'b1, 64'h2, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 1'b1, 64'h3, 1'b0, 1'b0, 1'b0);
    checkOutput("indep_mb_full", 64'(dispatcher_issue_ready), 64'd0);
    applyStimulus(1'b1, 1'b0, 64'h55, 1'b1, 1'b0, 1'b0);
    checkOutput("indep_po_ready", 64'(dispatcher_issue_ready), 64'd1);
    stepClock();
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("indep_po_valid", 64'(dispatcher_postoffice_valid), 64'd1);
    checkOutput("indep_po_data", dispatcher_postoffice_data, 64'h55);
    checkOutput("indep_mb_head", dispatcher_mailbox_data, 64'h1);
    stepClock();
    checkOutput("indep_po_drained", 64'(dispatcher_postoffice_valid), 64'd0);

    // Flush with two entries in each queue while a request is offered
    applyStimulus(1'b1, 1'b0, 64'h66, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 1'b0, 64'h77, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 1'b0, 64'h99, 1'b1, 1'b1, 1'b1);
    checkOutput("flush_ready", 64'(dispatcher_issue_ready), 64'd0);
    checkOutput("flush_po_valid", 64'(dispatcher_postoffice_valid), 64'd0);
    checkOutput("flush_mb_valid", 64'(dispatcher_mailbox_valid), 64'd0);
    checkOutput("flush_idle_during", 64'(dispatcher_idle), 64'd0);
    stepClock();
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_po_after", 64'(dispatcher_postoffice_valid), 64'd0);
    checkOutput("flush_mb_after", 64'(dispatcher_mailbox_valid), 64'd0);
    checkOutput("flush_idle_after", 64'(dispatcher_idle), 64'd1);

    // Push and pop the post office in the same cycle; count stays at 1
    applyStimulus(1'b1, 1'b0, 64'h100, 1'b1, 1'b0, 1'b0);
    checkOutput("pp_no_bypass", 64'(dispatcher_postoffice_valid), 64'd0);
    stepClock();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 64'h101 + 64'(i), 1'b1, 1'b0, 1'b0);
      checkOutput("pp_ready", 64'(dispatcher_issue_ready), 64'd1);
      checkOutput("pp_valid", 64'(dispatcher_postoffice_valid), 64'd1);
      checkOutput("pp_data", dispatcher_postoffice_data, 64'h100 + 64'(i));
      stepClock();
    end
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("pp_last_data", dispatcher_postoffice_data, 64'h108);
    checkOutput("pp_last_valid", 64'(dispatcher_postoffice_valid), 64'd1);
    stepClock();
    checkOutput("pp_drained", 64'(dispatcher_postoffice_valid), 64'd0);
    checkOutput("pp_idle", 64'(dispatcher_idle), 64'd1);

    // Asynchronous reset between edges with both queues non-empty
    applyStimulus(1'b1, 1'b0, 64'hAA, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 1'b1, 64'hBB, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 1'b0, 64'hEE, 1'b1, 1'b1, 1'b0);
    checkOutput("areset_po_before", dispatcher_postoffice_data, 64'hAA);
    checkOutput("areset_mb_before", dispatcher_mailbox_data, 64'hBB);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_po_valid", 64'(dispatcher_postoffice_valid), 64'd0);
    checkOutput("areset_mb_valid", 64'(dispatcher_mailbox_valid), 64'd0);
    checkOutput("areset_idle", 64'(dispatcher_idle), 64'd1);
    checkOutput("areset_ready", 64'(dispatcher_issue_ready), 64'd1);
    stepClock();
    checkOutput("areset_held_po", 64'(dispatcher_postoffice_valid), 64'd0);
    checkOutput("areset_held_idle", 64'(dispatcher_idle), 64'd1);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    stepClock();
    applyStimulus(1'b1, 1'b1, 64'hCD, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("resume_mb_valid", 64'(dispatcher_mailbox_valid), 64'd1);
    checkOutput("resume_mb_data", dispatcher_mailbox_data, 64'hCD);
    checkOutput("resume_po_empty", 64'(dispatcher_postoffice_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
